fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of one FIFO among NUM_REQ producers. A granted producer may hold the port for a burst of up to MAX_BURST words. The block respects the FIFO `full` flag and feeds the FIFO's `write`/`data_in` directly; it sits between producer blocks and a FIFO instance.

Parameters:
DATA_WIDTH, 16, word width; must equal the FIFO's DATA_WIDTH.
NUM_REQ, 4, number of producers (2..16).
MAX_BURST, 8, maximum consecutive words per grant (≥1).
(localparams: IDX_W = clog2(NUM_REQ), CNT_W = clog2(MAX_BURST+1))

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
req  in  NUM_REQ  per-producer request; high means "word valid on my data slice".
req_data  in  NUM_REQ*DATA_WIDTH  producer data; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
gnt  out  NUM_REQ  one-hot; gnt[i] high means the word of producer i is written this cycle.
fifo_full  in  1  FIFO full flag.
fifo_write  out  1  FIFO write request.
fifo_data  out  DATA_WIDTH  FIFO write data.
owner  out  IDX_W  index of the current burst owner; valid while busy.
busy  out  1  high in state BURST.

Behaviour:
- Write path is combinational, zero latency: fifo_write = |gnt; fifo_data = req_data slice of the granted index, or all-zero when there is no grant.
- gnt[i] is high only when req[i] is high and fifo_full is low. At most one grant bit is high per cycle.
- While rst is high, gnt and fifo_write are forced to 0.
- Reset values:
  - state = IDLE, busy = 0
  - last = NUM_REQ-1, so producer 0 has first priority
  - cnt = 0, owner = 0
- State IDLE:
  - If fifo_full is low and any req is high, pick the first requester searching from last+1 with wrap-around. Grant it the same cycle.
  - Then owner = winner, last = winner, cnt = 1.
  - Next state is BURST if MAX_BURST > 1, otherwise stay IDLE.
- State BURST:
  - If req[owner] is high and cnt < MAX_BURST: grant owner while fifo_full is low, and increment cnt on each granted word.
  - If fifo_full is high: no grant, cnt held, owner kept, stay in BURST.
  - Burst end: req[owner] low, or cnt == MAX_BURST. Re-arbitrate in the same cycle with no bubble, exactly as IDLE does.
    - The search starts at owner+1, so the previous owner has lowest priority.
    - The previous owner can win again only if it is the sole requester; it then starts a fresh burst with cnt = 1.
    - If nothing is granted, go to IDLE.
- Producers must hold req and data stable until their gnt is seen. A producer dropping req without a grant is legal and simply withdraws.
- Reset mid-burst: the state is abandoned immediately with no write on the reset cycle, and the FIFO contents are unaffected.
- fifo_full changing: the arbiter never writes while fifo_full is high. It relies on the FIFO deasserting full combinationally or registered; both are safe because the grant is gated on the sampled level.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds output port stat_cnt [NUM_REQ*16-1:0].
  - One 16-bit saturating counter per producer, incremented on every gnt[i].
  - Counters cleared by rst; they hold at 16'hFFFF on saturation.
- Undefined: the port and its counters are absent. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - arb_state_t enum (IDLE, BURST)
  - default DATA_WIDTH constant
  - clog2 function
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector and start index.
  - Outputs: found flag and winner index.
  - Used for both the IDLE and burst-end arbitration.

Test Plan:
1. Reset, then req=4'b0001 with data 1,2,3 over 3 cycles → gnt[0] each cycle, fifo_data 1,2,3, busy=1, owner=0; req drops → IDLE next cycle.
2. req=4'b1111 held, MAX_BURST=8 → 8 grants to producer 0, then 8 to 1, 8 to 2, 8 to 3, then 0 again. No idle cycle at handovers. gnt is one-hot every cycle.
3. Owner 2 mid-burst (cnt=3), fifo_full=1 for 5 cycles → gnt=0 and fifo_write=0. After full drops, 5 more words go to owner 2, for a total of 8.
4. Only req[1] held for 20 cycles → bursts of 8, 8, 4 to producer 1, back-to-back, with cnt restarting at 1 each burst.
5. rst asserted during a burst (owner 3, cnt=5) → gnt=0 that cycle. After release with req=4'b1001, producer 0 wins first.
6. With ARB_STATS_EN, scenario 2 run 64 cycles → stat_cnt slices all equal 16. Force 70000 grants to producer 0 → its slice reads 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_pkg: shared arbiter state type, default word width and clog2 helper
package fifo_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int DEF_DATA_WIDTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit at or after start (wrapping)
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // scan from the far end backwards so the candidate nearest to start wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = W'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for one FIFO write port (ARB_STATS_EN adds grant counters)
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8,
    localparam int IDX_W     = clog2(NUM_REQ),
    localparam int CNT_W     = clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [IDX_W-1:0]              owner,
    output logic                          busy
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [IDX_W-1:0] TOP_I = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] start, win, sel;
    logic             found, cont;

    assign start = (last_q == TOP_I) ? '0 : last_q + IDX_W'(1);

    rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
        .req   (req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    assign cont       = (state_q == BURST) && req[owner_q] && (cnt_q < MAX_C);
    assign fifo_write = |gnt;
    assign fifo_data  = fifo_write ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign owner      = owner_q;
    assign busy       = (state_q == BURST);

    // continue the current burst or re-arbitrate without a bubble; full or reset blocks all grants
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        sel     = '0;
        if (!rst && !fifo_full) begin
            if (cont) begin
                gnt[owner_q] = 1'b1;
                sel          = owner_q;
                cnt_d        = cnt_q + ONE_C;
            end else if (found) begin
                gnt[win] = 1'b1;
                sel      = win;
                owner_d  = win;
                last_d   = win;
                cnt_d    = ONE_C;
                state_d  = (MAX_BURST > 1) ? BURST : IDLE;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // arbiter state; last starts at the top index so producer 0 is first after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= TOP_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [15:0] stat_q;
        // per-producer grant counter that sticks at all-ones
        always_ff @(posedge clk) begin
            if (rst) stat_q <= '0;
            else if (gnt[i] && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
        end
        assign stat_cnt[i*16 +: 16] = stat_q;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus hand sequences for fifo_wr_arbiter (ARB_STATS_EN checks counters)
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_write;
    logic [15:0] fifo_data;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] dval;
    int          n_cmp = 0;
    int          n_bad = 0;
`ifdef ARB_STATS_EN
    logic [63:0] stat_cnt;
`endif

    fifo_wr_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .owner      (owner),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_cnt   (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic [15:0] d;
        logic        chk_st;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic f, input logic [15:0] d);
        rst       = r;
        req       = rq;
        fifo_full = f;
        dval      = d;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = d + 16'(i * 256);
    endtask

    // sample mid-cycle, then advance to just after the next rising edge
    task automatic cyc_chk(input string nm, input logic [3:0] eg, input logic eb, input logic [1:0] eo, input logic cs);
        logic [15:0] ed;
        ed = '0;
        for (int i = 0; i < 4; i++) if (eg[i]) ed = dval + 16'(i * 256);
        #3;
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".write"}, 32'(fifo_write), 32'(|eg));
        chk({nm, ".data"}, 32'(fifo_data), 32'(ed));
        if (cs) begin
            chk({nm, ".busy"}, 32'(busy), 32'(eb));
            chk({nm, ".owner"}, 32'(owner), 32'(eo));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0, 16'h0);
        cyc_chk("rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 4'b0000, 1'b0, 16'h0);
        //          rst   req      full  d       chk   gnt      busy  owner
        vt[0]  = '{1'b1, 4'b0001, 1'b0, 16'd0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vt[1]  = '{1'b1, 4'b0000, 1'b0, 16'd0, 1'b1, 4'b0000, 1'b0, 2'd0};
        vt[2]  = '{1'b0, 4'b0001, 1'b0, 16'd1, 1'b1, 4'b0001, 1'b0, 2'd0};
        vt[3]  = '{1'b0, 4'b0001, 1'b0, 16'd2, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[4]  = '{1'b0, 4'b0001, 1'b0, 16'd3, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[5]  = '{1'b0, 4'b0000, 1'b0, 16'd4, 1'b1, 4'b0000, 1'b1, 2'd0};
        vt[6]  = '{1'b0, 4'b0000, 1'b0, 16'd4, 1'b1, 4'b0000, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 4'b0011, 1'b1, 16'd5, 1'b1, 4'b0000, 1'b0, 2'd0};
        vt[8]  = '{1'b0, 4'b0011, 1'b0, 16'd5, 1'b1, 4'b0010, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 4'b0001, 1'b0, 16'd6, 1'b1, 4'b0001, 1'b1, 2'd1};
        vt[10] = '{1'b0, 4'b0000, 1'b0, 16'd7, 1'b1, 4'b0000, 1'b1, 2'd0};
        @(posedge clk);
        #1;
        for (int v = 0; v < 11; v++) begin
            drive(vt[v].rst, vt[v].req, vt[v].full, vt[v].d);
            cyc_chk($sformatf("vec%0d", v), vt[v].gnt, vt[v].busy, vt[v].owner, vt[v].chk_st);
        end

        // all four requesting: 8-word bursts rotating 0,1,2,3,0 with no gap
        do_reset();
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 16'(c));
            cyc_chk($sformatf("rr%0d", c), 4'(1 << ((c / 8) % 4)), c > 0, c > 0 ? 2'(((c - 1) / 8) % 4) : 2'd0, 1'b1);
        end

        // full stalls owner 2 at cnt=3; burst still totals 8 words before handing to producer 1
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b0100, 1'b0, 16'(c));
            cyc_chk($sformatf("fa%0d", c), 4'b0100, c > 0, c > 0 ? 2'd2 : 2'd0, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0110, 1'b1, 16'(c));
            cyc_chk($sformatf("fs%0d", c), 4'b0000, 1'b1, 2'd2, 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0110, 1'b0, 16'(c + 8));
            cyc_chk($sformatf("fr%0d", c), 4'b0100, 1'b1, 2'd2, 1'b1);
        end
        drive(1'b0, 4'b0110, 1'b0, 16'd20);
        cyc_chk("fh", 4'b0010, 1'b1, 2'd2, 1'b1);

        // sole requester 1 for 20 cycles, then its 4-word third burst runs to 8 before producer 0
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 4'b0010, 1'b0, 16'(c));
            cyc_chk($sformatf("so%0d", c), 4'b0010, c > 0, c > 0 ? 2'd1 : 2'd0, 1'b1);
        end
        for (int c = 20; c < 24; c++) begin
            drive(1'b0, 4'b0011, 1'b0, 16'(c));
            cyc_chk($sformatf("so%0d", c), 4'b0010, 1'b1, 2'd1, 1'b1);
        end
        drive(1'b0, 4'b0011, 1'b0, 16'd24);
        cyc_chk("so24", 4'b0001, 1'b1, 2'd1, 1'b1);

        // reset while owner 3 is mid-burst, then producer 0 has priority
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b1000, 1'b0, 16'(c));
            cyc_chk($sformatf("mr%0d", c), 4'b1000, c > 0, c > 0 ? 2'd3 : 2'd0, 1'b1);
        end
        drive(1'b1, 4'b1000, 1'b0, 16'd9);
        cyc_chk("mr_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(1'b0, 4'b1001, 1'b0, 16'd10);
        cyc_chk("mr_post", 4'b0001, 1'b0, 2'd0, 1'b1);

`ifdef ARB_STATS_EN
        do_reset();
        for (int c = 0; c < 64; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 16'(c));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("stat%0d", i), 32'(stat_cnt[i*16 +: 16]), 32'd16);
        drive(1'b0, 4'b0001, 1'b0, 16'd0);
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk);
        end
        #1;
        chk("stat_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
        chk("stat1_hold", 32'(stat_cnt[31:16]), 32'd16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
